stream_gate: RTL and testbench
==============================

# stream_gate

Multi-channel, mode-programmable stream gate, the next generation of the single-stream enable/discard sink. One configuration beat sets a per-channel mode and beat limit for NUM_CHANNELS parallel `ndata_i` streams. Each channel can forward, silently drop, drop but keep an empty end-of-stream marker, or truncate its stream to its first N beats. It sits between stream producers and downstream operators, so a host can prune or shorten streams per query without reconfiguring the pipeline.

## Interface
Parameters:
- NUM_CHANNELS, 4, number of independent stream channels.
- LIMIT_WIDTH, 16, width of the per-channel HEAD beat limit.
- ENABLE_SKID_BUFFER, 1, when 1 each output is registered through a skid buffer.
- data_t / NUM_ELEMENTS are taken from the `in` interface, not passed as parameters.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous and active-low.
- config  ready_valid_i.s  gate_cfg_t[NUM_CHANNELS]  one mode/limit entry per channel.
- in[NUM_CHANNELS]  ndata_i.s  data_t×NUM_ELEMENTS + keep + last  input streams.
- out[NUM_CHANNELS]  ndata_i.m  same  gated output streams.
- busy  out  NUM_CHANNELS  channel holds an active configuration.

## Operation
- Modes (gate_mode_t, 2 bits): PASS, DROP, MARK, HEAD.
- Per-channel FSM states: IDLE, PASS, DROP, MARK, HEAD, DRAIN.
- Config acceptance:
  - config.ready = 1 when every channel is IDLE or completing its input last beat this cycle. This is combinational from registered state plus in handshakes, with no dependence on config.valid.
  - On a config handshake, every channel loads its entry, clears its beat counter, and enters its mode state.
- IDLE: in.ready=0, internal valid=0.
- PASS: in.ready = downstream ready; forward data/keep/last unchanged.
- DROP: in.ready=1; nothing forwarded.
- MARK: non-last beats are consumed with in.ready=1 and not forwarded. The last beat is presented downstream with keep all-zero and last=1, so in.ready on that beat = downstream ready.
- HEAD with limit L:
  - Forward beats, incrementing the counter per forwarded beat.
  - On the beat where count==L−1: if not last, forward it with last forced to 1 and go to DRAIN. If it is last, forward unchanged and finish.
  - L=0 behaves exactly as MARK.
- DRAIN: in.ready=1, nothing forwarded, until the input last beat.
- Channel returns to IDLE on the input handshake carrying last=1, in every mode.
- The counter saturates at L and never wraps. L ranges 0…2^LIMIT_WIDTH−1.
- Output: data, keep and last are forwarded unchanged in all modes except the MARK end-of-stream marker (keep=0) and the HEAD truncation beat (last forced to 1).

## Timing
- Reset (async assert): all channels IDLE, counters 0, busy=0, in.ready=0, out.valid=0. config.ready reads 1 once reset deasserts.
- Latency: 0 cycles in→out with ENABLE_SKID_BUFFER=0, 1 cycle with it. Full throughput (1 beat/cycle/channel) in all modes.
- A config handshake and the final last-beat handshake of the last busy channel may coincide. The new config takes effect next cycle with no bubble beyond that.
- Channels are independent while busy. A channel that finishes early idles (in.ready=0) until the next config.
- Reset mid-stream discards the active configuration and any skid-buffer contents. No partial last is emitted.
- No combinational path from out.ready to config.ready except through the last-beat handshake.

## Structure
- stream_gate_pkg holds:
  - gate_mode_t enum: PASS=0, DROP=1, MARK=2, HEAD=3.
  - gate_cfg_t struct {gate_mode_t mode; logic[LIMIT_WIDTH-1:0] limit}. LIMIT_WIDTH is a package constant, 16.
- Sub-module stream_gate_channel contains one channel's FSM, counter and optional NDataSkidBuffer. The top instantiates it NUM_CHANNELS times via generate and builds the config.ready reduction.

## Test plan
- PASS: config all-PASS; ch0 sends 5 beats, last on beat 5 → out0 carries the identical 5 beats; busy[0] drops after beat 5.
- DROP/MARK: ch1=DROP, ch2=MARK, 4 beats each → out1 silent, in1 accepts 4 beats back-to-back; out2 carries exactly 1 beat with keep=0, last=1.
- HEAD truncation: ch0=HEAD L=3, 8-beat stream → out0 carries beats 1–3 with last=1 on beat 3; beats 4–8 consumed; channel goes IDLE after input beat 8.
- HEAD edge cases:
  - L=0 → identical to MARK.
  - L=10 with a 4-beat stream → all 4 beats forwarded, last on beat 4.
- Config overlap: second config presented while ch3 is still busy → config.ready=0 until ch3's last handshake, then accepted that same cycle. Random out.ready backpressure confirms no loss or duplication.
- Reset mid-stream: assert rst_n low during beat 2 of a PASS stream → out.valid, in.ready and busy go 0 immediately. After release, config.ready=1.

Source files
------------

// File: rtl/stream_gate_pkg.sv
// Shared types for the multi-channel stream gate: gate modes, per-channel config
// entry, channel FSM states and the beat payload carried through the skid buffer.
package stream_gate_pkg;

    localparam int LIMIT_WIDTH   = 16;
    localparam int NUM_ELEMENTS  = 4;
    localparam int ELEMENT_WIDTH = 8;

    typedef logic [ELEMENT_WIDTH-1:0] data_t;

    typedef enum logic [1:0] {
        PASS = 2'd0,
        DROP = 2'd1,
        MARK = 2'd2,
        HEAD = 2'd3
    } gate_mode_t;

    typedef struct packed {
        gate_mode_t             mode;
        logic [LIMIT_WIDTH-1:0] limit;
    } gate_cfg_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PASS,
        ST_DROP,
        ST_MARK,
        ST_HEAD,
        ST_DRAIN
    } chan_state_t;

    typedef struct packed {
        data_t [NUM_ELEMENTS-1:0] data;
        logic  [NUM_ELEMENTS-1:0] keep;
        logic                     last;
    } beat_t;

    // HEAD with a zero limit is indistinguishable from MARK, so it enters MARK directly.
    function automatic chan_state_t mode_state(input gate_mode_t mode,
                                               input logic [LIMIT_WIDTH-1:0] limit);
        chan_state_t st;
        case (mode)
            PASS:    st = ST_PASS;
            DROP:    st = ST_DROP;
            MARK:    st = ST_MARK;
            default: st = (limit == '0) ? ST_MARK : ST_HEAD;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/stream_gate_if.sv
// Handshake bundles: ndata_i carries a multi-element data beat with keep/last,
// ready_valid_i carries one configuration beat holding an entry per channel.
interface ndata_i;
    logic                                                   valid;
    logic                                                   ready;
    stream_gate_pkg::data_t [stream_gate_pkg::NUM_ELEMENTS-1:0] data;
    logic [stream_gate_pkg::NUM_ELEMENTS-1:0]               keep;
    logic                                                   last;

    modport m (output valid, data, keep, last, input ready);
    modport s (input valid, data, keep, last, output ready);
endinterface

interface ready_valid_i #(parameter int N = 4);
    logic                                 valid;
    logic                                 ready;
    stream_gate_pkg::gate_cfg_t [N-1:0]   data;

    modport m (output valid, data, input ready);
    modport s (input valid, data, output ready);
endinterface

// File: rtl/stream_gate_channel.sv
// One gate channel: mode FSM with HEAD beat counter, followed by an optional
// two-entry skid buffer that registers the output and decouples out.ready.
module stream_gate_channel
    import stream_gate_pkg::*;
#(
    parameter int ENABLE_SKID_BUFFER = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      cfg_fire,
    input  gate_cfg_t cfg_entry,
    ndata_i.s         in_s,
    ndata_i.m         out_m,
    output logic      busy,
    output logic      cfg_ok
);

    chan_state_t            state_q, state_d;
    logic [LIMIT_WIDTH-1:0] limit_q, limit_d;
    logic [LIMIT_WIDTH-1:0] count_q, count_d;

    logic  in_ready;
    logic  in_fire;
    logic  int_valid;
    logic  down_ready;
    logic  head_cut;
    beat_t in_beat;
    beat_t int_beat;

    assign in_beat.data = in_s.data;
    assign in_beat.keep = in_s.keep;
    assign in_beat.last = in_s.last;

    // Only evaluated in ST_HEAD, where the limit is known to be nonzero.
    assign head_cut = (count_q == (limit_q - LIMIT_WIDTH'(1)));

    always_comb begin
        in_ready  = 1'b0;
        int_valid = 1'b0;
        int_beat  = in_beat;
        case (state_q)
            ST_PASS: begin
                in_ready  = down_ready;
                int_valid = in_s.valid;
            end
            ST_DROP, ST_DRAIN: begin
                in_ready = 1'b1;
            end
            ST_MARK: begin
                if (in_s.last) begin
                    in_ready      = down_ready;
                    int_valid     = in_s.valid;
                    int_beat.keep = '0;
                end else begin
                    in_ready = 1'b1;
                end
            end
            ST_HEAD: begin
                in_ready  = down_ready;
                int_valid = in_s.valid;
                if (head_cut) begin
                    int_beat.last = 1'b1;
                end
            end
            default: begin
                in_ready  = 1'b0;
                int_valid = 1'b0;
            end
        endcase
    end

    assign in_fire    = in_s.valid & in_ready;
    assign in_s.ready = in_ready;
    assign busy       = (state_q != ST_IDLE);
    assign cfg_ok     = (state_q == ST_IDLE) | (in_fire & in_s.last);

    always_comb begin
        state_d = state_q;
        limit_d = limit_q;
        count_d = count_q;
        if (cfg_fire) begin
            state_d = mode_state(cfg_entry.mode, cfg_entry.limit);
            limit_d = cfg_entry.limit;
            count_d = '0;
        end else if (in_fire) begin
            if (in_s.last) begin
                state_d = ST_IDLE;
            end else if ((state_q == ST_HEAD) && head_cut) begin
                state_d = ST_DRAIN;
            end
            if ((state_q == ST_HEAD) && (count_q != limit_q)) begin
                count_d = count_q + LIMIT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            limit_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            limit_q <= limit_d;
            count_q <= count_d;
        end
    end

    generate
        if (ENABLE_SKID_BUFFER != 0) begin : g_skid
            beat_t main_q, main_d;
            beat_t skid_q, skid_d;
            logic  main_valid_q, main_valid_d;
            logic  skid_valid_q, skid_valid_d;
            logic  up_fire;

            assign down_ready = ~skid_valid_q;
            assign up_fire    = int_valid & ~skid_valid_q;

            // The skid slot only fills when the main slot is stalled downstream.
            always_comb begin
                main_d       = main_q;
                main_valid_d = main_valid_q;
                skid_d       = skid_q;
                skid_valid_d = skid_valid_q;
                if (out_m.ready || !main_valid_q) begin
                    if (skid_valid_q) begin
                        main_d       = skid_q;
                        main_valid_d = 1'b1;
                        skid_valid_d = 1'b0;
                    end else begin
                        main_d       = int_beat;
                        main_valid_d = up_fire;
                    end
                end else if (up_fire) begin
                    skid_d       = int_beat;
                    skid_valid_d = 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_q       <= '0;
                    skid_q       <= '0;
                    main_valid_q <= 1'b0;
                    skid_valid_q <= 1'b0;
                end else begin
                    main_q       <= main_d;
                    skid_q       <= skid_d;
                    main_valid_q <= main_valid_d;
                    skid_valid_q <= skid_valid_d;
                end
            end

            assign out_m.valid = main_valid_q;
            assign out_m.data  = main_q.data;
            assign out_m.keep  = main_q.keep;
            assign out_m.last  = main_q.last;
        end else begin : g_direct
            assign down_ready  = out_m.ready;
            assign out_m.valid = int_valid;
            assign out_m.data  = int_beat.data;
            assign out_m.keep  = int_beat.keep;
            assign out_m.last  = int_beat.last;
        end
    endgenerate

endmodule

// File: rtl/stream_gate.sv
// Multi-channel stream gate: one config beat programs every channel's mode and
// limit; a new config is accepted only once every channel is idle or finishing.
module stream_gate
    import stream_gate_pkg::*;
#(
    parameter int NUM_CHANNELS       = 4,
    parameter int ENABLE_SKID_BUFFER = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ready_valid_i.s                 cfg,
    ndata_i.s                       in  [NUM_CHANNELS],
    ndata_i.m                       out [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0] busy
);

    logic [NUM_CHANNELS-1:0] cfg_ok;
    logic                    cfg_ready;
    logic                    cfg_fire;

    assign cfg_ready = &cfg_ok;
    assign cfg_fire  = cfg.valid & cfg_ready;
    assign cfg.ready = cfg_ready;

    generate
        for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
            stream_gate_channel #(
                .ENABLE_SKID_BUFFER (ENABLE_SKID_BUFFER)
            ) u_chan (
                .clk       (clk),
                .rst_n     (rst_n),
                .cfg_fire  (cfg_fire),
                .cfg_entry (cfg.data[gi]),
                .in_s      (in[gi]),
                .out_m     (out[gi]),
                .busy      (busy[gi]),
                .cfg_ok    (cfg_ok[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_stream_gate.sv
// Scenario bench for stream_gate: expected beats are queued per channel as input
// beats are driven and popped by the output monitor on every output handshake.
`timescale 1ns/1ps
module tb_stream_gate;
    import stream_gate_pkg::*;

    localparam int NCH = 4;

    logic clk;
    logic rst_n;

    logic                  cfg_valid;
    wire                   cfg_ready;
    gate_cfg_t [NCH-1:0]   cfg_data;

    logic [NCH-1:0] in_valid;
    logic [NCH-1:0] in_last;
    logic [31:0]    in_data [NCH];
    logic [3:0]     in_keep [NCH];
    wire  [NCH-1:0] in_ready;

    wire  [NCH-1:0] out_valid;
    wire  [NCH-1:0] out_last;
    wire  [31:0]    out_data [NCH];
    wire  [3:0]     out_keep [NCH];
    logic [NCH-1:0] out_ready;
    wire  [NCH-1:0] busy;

    logic bp_en;
    int   checks = 0;
    int   errors = 0;
    logic [36:0] exp_q [NCH][$];
    time  last_hs_t [NCH];

    ready_valid_i #(.N(NCH)) cfg_if ();
    ndata_i in_if  [NCH] ();
    ndata_i out_if [NCH] ();

    assign cfg_if.valid = cfg_valid;
    assign cfg_if.data  = cfg_data;
    assign cfg_ready    = cfg_if.ready;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_conn
            assign in_if[gi].valid = in_valid[gi];
            assign in_if[gi].data  = in_data[gi];
            assign in_if[gi].keep  = in_keep[gi];
            assign in_if[gi].last  = in_last[gi];
            assign in_ready[gi]    = in_if[gi].ready;
            assign out_valid[gi]   = out_if[gi].valid;
            assign out_data[gi]    = out_if[gi].data;
            assign out_keep[gi]    = out_if[gi].keep;
            assign out_last[gi]    = out_if[gi].last;
            assign out_if[gi].ready = out_ready[gi];
        end
    endgenerate

    stream_gate #(
        .NUM_CHANNELS       (NCH),
        .ENABLE_SKID_BUFFER (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cfg   (cfg_if),
        .in    (in_if),
        .out   (out_if),
        .busy  (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    // Downstream backpressure, random when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_en ? NCH'($urandom) : '1;
        end
    end

    // Output monitor: every output handshake must match the head of its channel queue.
    initial begin
        forever begin
            @(negedge clk);
            for (int c = 0; c < NCH; c++) begin
                if (rst_n && out_valid[c] && out_ready[c]) begin
                    logic [36:0] got;
                    logic [36:0] e;
                    got = {out_data[c], out_keep[c], out_last[c]};
                    checks++;
                    if (exp_q[c].size() == 0) begin
                        errors++;
                        $display("FAIL out%0d_unexpected: got data=%h keep=%h last=%b, required no beat",
                                 c, got[36:5], got[4:1], got[0]);
                    end else begin
                        e = exp_q[c].pop_front();
                        if (got !== e) begin
                            errors++;
                            $display("FAIL out%0d_beat: got data=%h keep=%h last=%b, required data=%h keep=%h last=%b",
                                     c, got[36:5], got[4:1], got[0], e[36:5], e[4:1], e[0]);
                        end else begin
                            $display("[%0t] out%0d data=%h keep=%h last=%b ok",
                                     $time, c, got[36:5], got[4:1], got[0]);
                        end
                    end
                end
            end
        end
    end

    function automatic gate_cfg_t mk(input gate_mode_t m, input int lim);
        gate_cfg_t r;
        r.mode  = m;
        r.limit = LIMIT_WIDTH'(lim);
        return r;
    endfunction

    task automatic send_cfg(input gate_cfg_t [NCH-1:0] c, output time t);
        bit hs;
        int waited;
        hs = 0;
        waited = 0;
        t = 0;
        cfg_data  = c;
        cfg_valid = 1'b1;
        while (!hs && waited < 200) begin
            @(negedge clk);
            hs = cfg_ready;
            @(posedge clk);
            t = $time;
            #1;
            waited++;
        end
        cfg_valid = 1'b0;
        if (!hs) begin
            errors++;
            $display("FAIL cfg_timeout: config not accepted after %0d cycles, required acceptance", waited);
        end
    endtask

    // Drives an n-beat stream on one channel and queues what the gate must emit.
    task automatic send_stream(input int ch, input int n, input gate_mode_t mode,
                               input int lim, output int stalls);
        stalls = 0;
        for (int i = 1; i <= n; i++) begin
            logic [31:0] d;
            logic [3:0]  k;
            logic        lst;
            logic [36:0] e;
            bit          fwd;
            bit          hs;
            int          waited;
            d      = $urandom;
            k      = 4'($urandom_range(1, 15));
            lst    = (i == n);
            e      = {d, k, lst};
            fwd    = 0;
            hs     = 0;
            waited = 0;
            case (mode)
                PASS: fwd = 1;
                MARK: begin
                    fwd = lst;
                    e   = {d, 4'b0000, 1'b1};
                end
                HEAD: begin
                    if (lim == 0) begin
                        fwd = lst;
                        e   = {d, 4'b0000, 1'b1};
                    end else if (i <= lim) begin
                        fwd  = 1;
                        e[0] = lst || (i == lim);
                    end
                end
                default: fwd = 0;
            endcase
            if (fwd) exp_q[ch].push_back(e);
            in_data[ch]  = d;
            in_keep[ch]  = k;
            in_last[ch]  = lst;
            in_valid[ch] = 1'b1;
            while (!hs && waited < 200) begin
                @(negedge clk);
                hs = in_ready[ch];
                @(posedge clk);
                if (hs) last_hs_t[ch] = $time;
                #1;
                if (!hs) begin
                    stalls++;
                    waited++;
                end
            end
            if (!hs) begin
                errors++;
                $display("FAIL in%0d_timeout: beat %0d not accepted after %0d cycles, required acceptance",
                         ch, i, waited);
                break;
            end
        end
        in_valid[ch] = 1'b0;
        in_last[ch]  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = '1;
        in_last  = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== '0) begin
            errors++;
            $display("FAIL reset_busy: got %b, required 0000", busy);
        end
        checks++;
        if (out_valid !== '0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b, required 0000", out_valid);
        end
        checks++;
        if (in_ready !== '0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required 0000", in_ready);
        end
        in_valid = '0;
        in_last  = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_cfg_ready: got %b, required 1", cfg_ready);
        end
        @(posedge clk);
        #1;
        $display("test_reset done");
    endtask

    task automatic test_pass();
        gate_cfg_t [NCH-1:0] c;
        time t;
        int s0, s1, s2, s3;
        for (int i = 0; i < NCH; i++) c[i] = mk(PASS, 0);
        send_cfg(c, t);
        checks++;
        if (busy !== 4'hF) begin
            errors++;
            $display("FAIL pass_busy_loaded: got %b, required 1111", busy);
        end
        fork
            send_stream(0, 5, PASS, 0, s0);
            send_stream(1, 1, PASS, 0, s1);
            send_stream(2, 1, PASS, 0, s2);
            send_stream(3, 1, PASS, 0, s3);
        join
        checks++;
        if (busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL pass_busy_after_last: got %b, required 0", busy[0]);
        end
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < NCH; i++) begin
            checks++;
            if (exp_q[i].size() != 0) begin
                errors++;
                $display("FAIL pass_out%0d_missing: %0d beats not seen, required 0", i, exp_q[i].size());
            end
        end
        $display("test_pass done");
    endtask

    task automatic test_drop_mark();
        gate_cfg_t [NCH-1:0] c;
        time t;
        int s0, s1, s2, s3;
        c[0] = mk(PASS, 0);
        c[1] = mk(DROP, 0);
        c[2] = mk(MARK, 0);
        c[3] = mk(PASS, 0);
        send_cfg(c, t);
        fork
            send_stream(0, 1, PASS, 0, s0);
            send_stream(1, 4, DROP, 0, s1);
            send_stream(2, 4, MARK, 0, s2);
            send_stream(3, 1, PASS, 0, s3);
        join
        checks++;
        if (s1 !== 0) begin
            errors++;
            $display("FAIL drop_back_to_back: got %0d stall cycles, required 0", s1);
        end
        checks++;
        if (busy !== '0) begin
            errors++;
            $display("FAIL drop_mark_busy_end: got %b, required 0000", busy);
        end
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < NCH; i++) begin
            checks++;
            if (exp_q[i].size() != 0) begin
                errors++;
                $display("FAIL drop_mark_out%0d_missing: %0d beats not seen, required 0", i, exp_q[i].size());
            end
        end
        $display("test_drop_mark done");
    endtask

    task automatic test_head();
        gate_cfg_t [NCH-1:0] c;
        time t;
        int s0, s1, s2, s3;
        c[0] = mk(HEAD, 3);
        c[1] = mk(HEAD, 0);
        c[2] = mk(HEAD, 10);
        c[3] = mk(HEAD, 1);
        send_cfg(c, t);
        fork
            send_stream(0, 8, HEAD, 3, s0);
            send_stream(1, 4, HEAD, 0, s1);
            send_stream(2, 4, HEAD, 10, s2);
            send_stream(3, 3, HEAD, 1, s3);
        join
        checks++;
        if (s0 !== 0) begin
            errors++;
            $display("FAIL head_drain_stalls: got %0d stall cycles, required 0", s0);
        end
        checks++;
        if (busy !== '0) begin
            errors++;
            $display("FAIL head_busy_end: got %b, required 0000", busy);
        end
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < NCH; i++) begin
            checks++;
            if (exp_q[i].size() != 0) begin
                errors++;
                $display("FAIL head_out%0d_missing: %0d beats not seen, required 0", i, exp_q[i].size());
            end
        end
        $display("test_head done");
    endtask

    task automatic test_overlap();
        gate_cfg_t [NCH-1:0] c1;
        gate_cfg_t [NCH-1:0] c2;
        time t1, t2;
        int s0, s1, s2, s3;
        for (int i = 0; i < NCH; i++) c1[i] = mk(PASS, 0);
        c2[0] = mk(PASS, 0);
        c2[1] = mk(HEAD, 4);
        c2[2] = mk(MARK, 0);
        c2[3] = mk(PASS, 0);
        send_cfg(c1, t1);
        bp_en = 1'b1;
        fork
            send_stream(0, 1, PASS, 0, s0);
            send_stream(1, 1, PASS, 0, s1);
            send_stream(2, 1, PASS, 0, s2);
            send_stream(3, 8, PASS, 0, s3);
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                checks++;
                if (cfg_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL overlap_ready_while_busy: got %b, required 0", cfg_ready);
                end
                @(posedge clk);
                #1;
                send_cfg(c2, t2);
            end
        join
        checks++;
        if (t2 !== last_hs_t[3]) begin
            errors++;
            $display("FAIL overlap_same_cycle: config accepted at %0t, required %0t", t2, last_hs_t[3]);
        end
        checks++;
        if (busy !== 4'hF) begin
            errors++;
            $display("FAIL overlap_new_cfg_busy: got %b, required 1111", busy);
        end
        fork
            send_stream(0, 6, PASS, 0, s0);
            send_stream(1, 6, HEAD, 4, s1);
            send_stream(2, 6, MARK, 0, s2);
            send_stream(3, 6, PASS, 0, s3);
        join
        bp_en = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (busy !== '0) begin
            errors++;
            $display("FAIL overlap_busy_end: got %b, required 0000", busy);
        end
        for (int i = 0; i < NCH; i++) begin
            checks++;
            if (exp_q[i].size() != 0) begin
                errors++;
                $display("FAIL overlap_out%0d_missing: %0d beats not seen, required 0", i, exp_q[i].size());
            end
        end
        $display("test_overlap done");
    endtask

    task automatic test_reset_mid();
        gate_cfg_t [NCH-1:0] c;
        time t;
        logic [31:0] d;
        logic [3:0]  k;
        for (int i = 0; i < NCH; i++) c[i] = mk(PASS, 0);
        send_cfg(c, t);
        d = $urandom;
        k = 4'hF;
        exp_q[0].push_back({d, k, 1'b0});
        in_data[0]  = d;
        in_keep[0]  = k;
        in_last[0]  = 1'b0;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        in_data[0] = $urandom;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== '0) begin
            errors++;
            $display("FAIL midreset_out_valid: got %b, required 0000", out_valid);
        end
        checks++;
        if (in_ready !== '0) begin
            errors++;
            $display("FAIL midreset_in_ready: got %b, required 0000", in_ready);
        end
        checks++;
        if (busy !== '0) begin
            errors++;
            $display("FAIL midreset_busy: got %b, required 0000", busy);
        end
        in_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_cfg_ready: got %b, required 1", cfg_ready);
        end
        checks++;
        if (out_valid !== '0) begin
            errors++;
            $display("FAIL midreset_out_after: got %b, required 0000", out_valid);
        end
        for (int i = 0; i < NCH; i++) begin
            checks++;
            if (exp_q[i].size() != 0) begin
                errors++;
                $display("FAIL midreset_out%0d_missing: %0d beats not seen, required 0", i, exp_q[i].size());
            end
        end
        @(posedge clk);
        #1;
        $display("test_reset_mid done");
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        in_valid  = '0;
        in_last   = '0;
        out_ready = '1;
        bp_en     = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            in_data[i]   = '0;
            in_keep[i]   = '0;
            last_hs_t[i] = 0;
        end
        test_reset();
        test_pass();
        test_drop_mark();
        test_head();
        test_overlap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
